// File: rtl/alu_mc_if.sv
// Request/result bundle between the register-file read ports, the multi-cycle ALU
// and the writeback mux.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu;
    logic             zf;
    logic             nf;
    logic             cf;
    logic             vf;

    modport master (
        output start, alu_op, alu_A, alu_B,
        input  busy, done, alu, zf, nf, cf, vf
    );

    modport slave (
        input  start, alu_op, alu_A, alu_B,
        output busy, done, alu, zf, nf, cf, vf
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: seven single-edge operations plus an iterative shift-add MUL,
// with registered result, N/C/V/Z flags and a start/done handshake.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic     i_clk,
    input  logic     i_rst,
    alu_mc_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W:0] CNT_ONE  = (SH_W+1)'(1);
    localparam logic [SH_W:0] CNT_FULL = (SH_W+1)'(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [SH_W:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_alu;
    logic               r_zf, r_nf, r_cf, r_vf, r_done;

    logic               w_opLoad, w_mulLoad, w_mulStep, w_mulLast;
    logic [2*WIDTH-1:0] w_accNext;
    logic [SH_W-1:0]    w_shAmt;
    logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr;
    logic [WIDTH-1:0]   w_res;
    logic               w_cf, w_vf;

    assign w_shAmt   = bus.alu_B[SH_W-1:0];
    assign w_sum     = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
    assign w_diff    = {1'b0, bus.alu_A} - {1'b0, bus.alu_B};
    // The extra bit on each shift captures the last bit shifted out (0 for amount 0).
    assign w_shl     = {1'b0, bus.alu_A} << w_shAmt;
    assign w_shr     = {bus.alu_A, 1'b0} >> w_shAmt;
    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_nextState = r_state;
        w_opLoad    = 1'b0;
        w_mulLoad   = 1'b0;
        w_mulStep   = 1'b0;
        w_mulLast   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.alu_op == 3'b111) begin
                        w_mulLoad   = 1'b1;
                        w_nextState = MUL;
                    end else begin
                        w_opLoad = 1'b1;
                    end
                end
            end
            MUL: begin
                w_mulStep = 1'b1;
                if (r_cnt == CNT_ONE) begin
                    w_mulLast   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_cf  = 1'b0;
        w_vf  = 1'b0;
        case (bus.alu_op)
            3'b000: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_vf  = (bus.alu_A[WIDTH-1] == bus.alu_B[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.alu_A[WIDTH-1]);
            end
            3'b001: begin
                w_res = w_diff[WIDTH-1:0];
                w_cf  = w_diff[WIDTH];
                w_vf  = (bus.alu_A[WIDTH-1] != bus.alu_B[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.alu_A[WIDTH-1]);
            end
            3'b010: w_res = bus.alu_A & bus.alu_B;
            3'b011: w_res = bus.alu_A | bus.alu_B;
            3'b100: w_res = bus.alu_A ^ bus.alu_B;
            3'b101: begin
                w_res = w_shl[WIDTH-1:0];
                w_cf  = w_shl[WIDTH];
            end
            3'b110: begin
                w_res = w_shr[WIDTH:1];
                w_cf  = w_shr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_alu    <= '0;
            r_zf     <= 1'b0;
            r_nf     <= 1'b0;
            r_cf     <= 1'b0;
            r_vf     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_opLoad) begin
                r_alu  <= w_res;
                r_zf   <= (w_res == '0);
                r_nf   <= w_res[WIDTH-1];
                r_cf   <= w_cf;
                r_vf   <= w_vf;
                r_done <= 1'b1;
            end
            if (w_mulLoad) begin
                r_mcand  <= {{WIDTH{1'b0}}, bus.alu_A};
                r_mplier <= bus.alu_B;
                r_acc    <= '0;
                r_cnt    <= CNT_FULL;
            end
            // One multiplier bit per edge; the final partial sum is written straight out.
            if (w_mulStep) begin
                r_acc    <= w_accNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_ONE;
            end
            if (w_mulLast) begin
                r_alu  <= w_accNext[WIDTH-1:0];
                r_zf   <= (w_accNext[WIDTH-1:0] == '0);
                r_nf   <= w_accNext[WIDTH-1];
                r_cf   <= |w_accNext[2*WIDTH-1:WIDTH];
                r_vf   <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.busy = (r_state == MUL);
    assign bus.done = r_done;
    assign bus.alu  = r_alu;
    assign bus.zf   = r_zf;
    assign bus.nf   = r_nf;
    assign bus.cf   = r_cf;
    assign bus.vf   = r_vf;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): directed cases plus random operations
// compared against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference results from plain integer arithmetic on the operation definitions.
    function automatic void refModel(input logic [2:0] op, input logic [15:0] a,
                                     input logic [15:0] b, output logic [15:0] res,
                                     output logic c, output logic v);
        int     sa, sb, full, s;
        longint p;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        s   = int'(b) % W;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            3'd0: begin
                full = int'(a) + int'(b);
                res  = 16'(full);
                c    = (full > 65535);
                v    = (sa + sb > 32767) || (sa + sb < -32768);
            end
            3'd1: begin
                full = int'(a) - int'(b);
                res  = 16'(full);
                c    = (a < b);
                v    = (sa - sb > 32767) || (sa - sb < -32768);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                res = 16'(int'(a) << s);
                c   = (s == 0) ? 1'b0 : 1'((int'(a) >> (W - s)) & 1);
            end
            3'd6: begin
                res = 16'(int'(a) >> s);
                c   = (s == 0) ? 1'b0 : 1'((int'(a) >> (s - 1)) & 1);
            end
            default: begin
                p   = longint'(a) * longint'(b);
                res = 16'(p);
                c   = ((p >> 16) != 0);
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.alu_A  = a;
        bus.alu_B  = b;
        tick();
        bus.start  = 1'b0;
    endtask

    // Issues one operation and returns in the cycle where done is high.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input bit inject);
        logic [15:0] expRes, prevAlu;
        logic        expC, expV;
        int          edges, busyCnt, expLat;
        refModel(op, a, b, expRes, expC, expV);
        prevAlu = bus.alu;
        expLat  = (op == 3'd7) ? W + 1 : 1;
        applyStimulus(op, a, b);
        edges   = 1;
        busyCnt = 0;
        while (!bus.done && edges < W + 10) begin
            if (bus.busy) busyCnt++;
            checkOutput({tag, "/hold"}, 32'(bus.alu), 32'(prevAlu));
            if (inject) begin
                bus.start  = (edges == 6);
                bus.alu_op = 3'd0;
                bus.alu_A  = 16'h1111;
                bus.alu_B  = 16'h2222;
            end
            tick();
            edges++;
        end
        bus.start = 1'b0;
        checkOutput({tag, "/latency"}, 32'(edges), 32'(expLat));
        checkOutput({tag, "/busycycles"}, 32'(busyCnt), 32'(expLat - 1));
        checkOutput({tag, "/done"}, 32'(bus.done), 32'd1);
        checkOutput({tag, "/busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "/alu"}, 32'(bus.alu), 32'(expRes));
        checkOutput({tag, "/zf"}, 32'(bus.zf), 32'(expRes == 16'h0000));
        checkOutput({tag, "/nf"}, 32'(bus.nf), 32'(expRes[15]));
        checkOutput({tag, "/cf"}, 32'(bus.cf), 32'(expC));
        checkOutput({tag, "/vf"}, 32'(bus.vf), 32'(expV));
    endtask

    task automatic checkDoneDrop(input string tag);
        tick();
        checkOutput({tag, "/donedrop"}, 32'(bus.done), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/alu"}, 32'(bus.alu), 32'd0);
        checkOutput({tag, "/flags"}, {28'd0, bus.zf, bus.nf, bus.cf, bus.vf}, 32'd0);
        checkOutput({tag, "/busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "/done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int doneSeen;
        logic [2:0] op;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.alu_op = 3'd0;
        bus.alu_A  = '0;
        bus.alu_B  = '0;
        tick();
        tick();
        rst = 1'b0;
        checkAllZero("reset");

        // Reset must win over a simultaneous request.
        rst = 1'b1;
        applyStimulus(3'd0, 16'h1234, 16'h0001);
        rst = 1'b0;
        checkAllZero("rstprio");
        tick();
        checkAllZero("rstprio2");

        runOp("add", 3'd0, 16'h0DCA, 16'h0234, 1'b0);  checkDoneDrop("add");
        runOp("subz", 3'd1, 16'hF234, 16'hF234, 1'b0); checkDoneDrop("subz");
        runOp("subb", 3'd1, 16'h0234, 16'h0DCA, 1'b0); checkDoneDrop("subb");
        runOp("addv", 3'd0, 16'h7FFF, 16'h0001, 1'b0); checkDoneDrop("addv");
        runOp("addc", 3'd0, 16'hFFFF, 16'h0001, 1'b0); checkDoneDrop("addc");
        runOp("subv", 3'd1, 16'h8000, 16'h0001, 1'b0); checkDoneDrop("subv");
        runOp("shl", 3'd5, 16'h8001, 16'h0011, 1'b0);  checkDoneDrop("shl");
        runOp("shr0", 3'd6, 16'h0DCA, 16'h0000, 1'b0); checkDoneDrop("shr0");
        runOp("shr", 3'd6, 16'h0DCB, 16'h0001, 1'b0);  checkDoneDrop("shr");
        runOp("logic", 3'd4, 16'hA5A5, 16'h0FF0, 1'b0); checkDoneDrop("logic");

        runOp("mul", 3'd7, 16'h0DCA, 16'h0234, 1'b1);
        runOp("b2b", 3'd0, 16'h0001, 16'h0001, 1'b0);
        checkDoneDrop("b2b");

        // Abort a multiply just before its fifth iteration edge.
        applyStimulus(3'd7, 16'h0003, 16'h0005);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero("abort");
        doneSeen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (bus.done) doneSeen++;
        end
        checkOutput("abort/nodone", 32'(doneSeen), 32'd0);
        runOp("postabort", 3'd0, 16'h0001, 16'h0001, 1'b0);
        checkDoneDrop("postabort");

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            runOp("rand", op, 16'($urandom), 16'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) checkDoneDrop("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised successor to the datapath's 16-bit, 2-bit-opcode ALU. It adds an eight-operation set, registered results with a start/done handshake, and a full N/C/V/Z flag set. Single-cycle operations complete on the accepting edge. MUL is an iterative shift-add unit that runs for WIDTH cycles while `busy` is asserted. The block sits between the register-file read ports and the writeback mux, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 16: operand and result width. Must be a power of two, minimum 4. `SH_W = $clog2(WIDTH)`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled on every edge, accepted only when `busy`=0.
- `alu_op`  in  3  operation code, sampled when `start` is accepted.
- `alu_A`  in  WIDTH  operand A, sampled when `start` is accepted.
- `alu_B`  in  WIDTH  operand B, sampled when `start` is accepted.
- `busy`  out  1  high while a MUL is iterating.
- `done`  out  1  one-cycle pulse: result and flags have just been updated.
- `alu`  out  WIDTH  registered result.
- `zf`  out  1  zero flag: 1 when `alu`==0.
- `nf`  out  1  negative flag: equals `alu[WIDTH-1]`.
- `cf`  out  1  carry flag (per-operation rule below).
- `vf`  out  1  signed-overflow flag.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[SH_W-1:0], logical.
  - 110 SHR: A >> B[SH_W-1:0], logical.
  - 111 MUL: unsigned; the low WIDTH bits of A×B go to `alu`.
- Bits of B above SH_W are ignored for shifts.
- `cf` rules:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow, i.e. 1 when A<B unsigned.
  - SHL/SHR: the last bit shifted out; 0 when the shift amount is 0.
  - MUL: 1 when the high WIDTH bits of the 2·WIDTH product are non-zero.
  - AND/OR/XOR: 0.
- `vf` rules:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - All other operations: 0.
- `zf` and `nf` always reflect the newly written `alu`.
- State machine, two states:
  - IDLE: on `start`=1 with a non-MUL op, write `alu` and flags and pulse `done`; stay in IDLE.
  - IDLE: on `start`=1 with op 111, latch A and B, clear the 2·WIDTH accumulator, load the counter with WIDTH, and go to MUL.
  - MUL: each edge examines one multiplier bit, LSB first. If the bit is 1, add the shifted multiplicand to the accumulator. Then decrement the counter.
  - MUL: on the edge where the counter goes 1→0, write `alu` and flags, pulse `done`, and return to IDLE.
- `start` while `busy`=1 is ignored: no queueing, no error.
- `start` in the same cycle that `done` is high is accepted normally; back-to-back operations are legal.
- `alu` and all flags hold their values between operations; only a completing operation or `rst` changes them.
- Reset:
  - Sets `alu`=0, all flags 0, `busy`=0, `done`=0, state IDLE, counter 0.
  - Reset during MUL aborts the operation: no `done`, and `alu` is cleared.
  - `rst` has priority over a simultaneous `start`.

## Timing
- Non-MUL operation accepted at edge k: `alu`, flags and `done`=1 are visible after edge k. `done`=0 after edge k+1 unless a new operation completes at k+1.
- MUL accepted at edge k:
  - `busy`=1 after edges k through k+WIDTH−1.
  - Iterations occur at edges k+1 through k+WIDTH.
  - The result is written and `done`=1 after edge k+WIDTH, and `busy`=0 in that same cycle.
  - Total latency is WIDTH+1 edges; for WIDTH=16 this is 17.
- `done` is never high for two consecutive cycles for the same operation.
- During MUL, `alu` still shows the previous result and changes only at completion.

## Test plan
All scenarios use WIDTH=16.
- ADD 0x0DCA+0x0234 with a one-cycle `start` → next cycle `alu`=0x0FFE, zf=nf=cf=vf=0, `done`=1 for exactly one cycle.
- SUB 0xF234−0xF234 → `alu`=0x0000, zf=1, cf=0, vf=0. SUB 0x0234−0x0DCA → `alu`=0xF46A, nf=1, cf=1, vf=0.
- ADD 0x7FFF+0x0001 → `alu`=0x8000, vf=1, nf=1, cf=0. ADD 0xFFFF+0x0001 → `alu`=0, zf=1, cf=1, vf=0.
- SHL 0x8001 by B=0x0011 (amount 1) → `alu`=0x0002, cf=1. SHR 0x0DCA by 0 → `alu`=0x0DCA, cf=0.
- MUL 0x0DCA×0x0234:
  - `busy` is high for 16 cycles and `done` appears 17 edges after acceptance.
  - Result: `alu`=0x6108, cf=1 (high half 0x001E).
  - An ADD `start` pulsed mid-MUL is ignored and `alu` is unchanged until completion.
  - An ADD issued with `start` in the `done` cycle completes on the next edge.
- MUL 0x0003×0x0005 with `rst` asserted at iteration 5 → all outputs 0 and no `done`. A following ADD 0x0001+0x0001 → `alu`=0x0002.
